ysyx_22040386_mdu: RTL

YSYX_22040386_MDU -- requirements
Module: ysyx_22040386_mdu

---
 rtl/ysyx_22040386_mdu_pkg.sv | 21 ++
 rtl/ysyx_22040386_mdu_sign.sv | 82 ++++++++
 rtl/ysyx_22040386_mdu.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_mdu_pkg.sv
// Shared definitions for the iterative RV-M multiply/divide unit.
package ysyx_22040386_mdu_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/ysyx_22040386_mdu_sign.sv
// Operand magnitude/sign pre-processing, fast-path results
// and final sign fix-up for the MDU.
module ysyx_22040386_mdu_sign
  import ysyx_22040386_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]        funct3,
  input  logic              word,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  output logic [XLEN-1:0]   mag1,
  output logic [XLEN-1:0]   mag2,
  output logic              neg,
  output logic              fast,
  output logic [XLEN-1:0]   fast_res,
  input  logic [2:0]        fix_funct3,
  input  logic              fix_word,
  input  logic              fix_neg,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   fixed
);

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            sgn1, sgn2, n1, n2;
  logic            dz, ovf, illegal;
  logic [XLEN-1:0] x1, x2, v;

  always_comb begin
    sgn1 = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    sgn2 = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    x1 = src1;
    x2 = src2;
    if (word) begin
      x1 = sgn1 ? XLEN'($signed(src1[31:0])) : XLEN'(src1[31:0]);
      x2 = sgn2 ? XLEN'($signed(src2[31:0])) : XLEN'(src2[31:0]);
    end
    n1   = sgn1 & x1[XLEN-1];
    n2   = sgn2 & x2[XLEN-1];
    mag1 = n1 ? -x1 : x1;
    mag2 = n2 ? -x2 : x2;
    // remainder follows the dividend; product and quotient use both signs
    neg  = (funct3[2] & funct3[1]) ? n1 : (n1 ^ n2);
  end

  always_comb begin
    dz  = funct3[2] && (x2 == '0);
    ovf = 1'b0;
    if (funct3 == F3_DIV || funct3 == F3_REM) begin
      if (word)
        ovf = (src1[31:0] == 32'h8000_0000) && (src2[31:0] == '1);
      else
        ovf = (src1 == MIN) && (src2 == '1);
    end
    illegal = word && !funct3[2] && (funct3 != F3_MUL);
    fast    = dz | ovf | illegal;
    v = '0;
    if (dz)
      v = funct3[1] ? x1 : '1;
    else if (ovf)
      v = funct3[1] ? '0 : x1;
    fast_res = word ? XLEN'($signed(v[31:0])) : v;
  end

  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   q, r, f;

  always_comb begin
    p = fix_neg ? -prod : prod;
    q = fix_neg ? -quo : quo;
    r = fix_neg ? -rem : rem;
    if (!fix_funct3[2])
      f = (fix_funct3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else
      f = fix_funct3[1] ? r : q;
    fixed = fix_word ? XLEN'($signed(f[31:0])) : f;
  end

endmodule

// File: rtl/ysyx_22040386_mdu.sv
// Iterative RV-M multiply/divide unit: radix-2 shift-add
// multiply and restoring divide, one bit per cycle.
module ysyx_22040386_mdu
  import ysyx_22040386_mdu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            word_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam bit WEN = (XLEN == 32) ? 1'b0 : WORD_EN;
  localparam int CW  = $clog2(XLEN) + 1;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand, prod, prod_nxt;
  logic [XLEN-1:0]   mplier, quo, rem, dvsr;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;
  logic [2:0]        op_f3;
  logic              op_word, op_neg;

  logic            word, accept, last;
  logic [XLEN-1:0] mag1, mag2, fast_res, fixed;
  logic            neg, fast;

  assign word      = WEN && word_op;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (state == S_BUSY) && (cnt == CW'(1));

  ysyx_22040386_mdu_sign #(.XLEN(XLEN)) u_sign (
    .funct3     (funct3),
    .word       (word),
    .src1       (src1),
    .src2       (src2),
    .mag1       (mag1),
    .mag2       (mag2),
    .neg        (neg),
    .fast       (fast),
    .fast_res   (fast_res),
    .fix_funct3 (op_f3),
    .fix_word   (op_word),
    .fix_neg    (op_neg),
    .prod       (prod_nxt),
    .quo        (quo_nxt),
    .rem        (rem_nxt),
    .fixed      (fixed)
  );

  logic [XLEN:0] rs, sub;
  logic          ge;

  always_comb begin
    prod_nxt = mplier[0] ? (prod + mcand) : prod;
    rs       = {rem, quo[XLEN-1]};
    ge       = (rs >= {1'b0, dvsr});
    sub      = rs - {1'b0, dvsr};
    rem_nxt  = XLEN'(ge ? sub : rs);
    quo_nxt  = {quo[XLEN-2:0], ge};
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) state_nxt = fast ? S_DONE : S_BUSY;
        S_BUSY: if (last) state_nxt = S_DONE;
        S_DONE: if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      op_f3   <= '0;
      op_word <= 1'b0;
      op_neg  <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_f3   <= funct3;
      op_word <= word;
      op_neg  <= neg;
      cnt     <= fast ? '0 : (word ? CW'(32) : CW'(XLEN));
      mcand   <= {{XLEN{1'b0}}, mag1};
      mplier  <= mag2;
      prod    <= '0;
      // word dividends start at the top so 32 steps consume them
      quo     <= word ? (mag1 << (XLEN - 32)) : mag1;
      rem     <= '0;
      dvsr    <= mag2;
      if (fast) result <= fast_res;
    end else if (state == S_BUSY) begin
      cnt    <= cnt - CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_nxt;
      quo    <= quo_nxt;
      rem    <= rem_nxt;
      if (last) result <= fixed;
    end
  end

endmodule
